// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, fetches one word at a time over req/gnt/rvalid,
// buffers returned instructions in a small FIFO and flushes on execute redirects.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic [6:0]            opcode_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [ADDR_WIDTH-1:0] r_issue_pc;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  logic                  r_discard, w_discard_nxt;
  logic [31:0]           r_buf_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] r_buf_pc    [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  logic                  w_gnt_take, w_rsp, w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_redirect_pc = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_gnt_take    = (r_state == S_REQ) && imem_gnt_i;
  assign w_rsp         = (r_state == S_WAIT) && imem_rvalid_i;
  assign w_push        = w_rsp && !r_discard && !redirect_i;
  assign instr_valid_o = (r_count != '0);
  assign w_pop         = instr_valid_o && instr_ready_i && !redirect_i;

  assign imem_req_o  = (r_state == S_REQ);
  assign imem_addr_o = r_fetch_pc;
  assign instr_o     = instr_valid_o ? r_buf_instr[r_rd_ptr] : '0;
  assign instr_pc_o  = instr_valid_o ? r_buf_pc[r_rd_ptr] : '0;
  assign opcode_o    = instr_o[6:0];

  always_comb begin
    w_count_nxt = r_count;
    if (redirect_i) w_count_nxt = '0;
    else            w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Next-state: a new request is only issued once a buffer slot is guaranteed
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_discard_nxt  = r_discard;
    case (r_state)
      S_IDLE: if (w_count_nxt < CNT_W'(DEPTH)) w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          w_state_nxt    = S_WAIT;
          w_fetch_pc_nxt = r_fetch_pc + ADDR_WIDTH'(4);
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_discard_nxt = 1'b0;
          w_state_nxt   = (w_count_nxt < CNT_W'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A response still owed by memory must be swallowed, otherwise refetch at once
    if (redirect_i) begin
      w_fetch_pc_nxt = w_redirect_pc;
      if (w_gnt_take || ((r_state == S_WAIT) && !imem_rvalid_i)) begin
        w_state_nxt   = S_WAIT;
        w_discard_nxt = 1'b1;
      end else begin
        w_state_nxt   = S_REQ;
        w_discard_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_discard  <= w_discard_nxt;
      r_count    <= w_count_nxt;
      if (redirect_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  // Buffer storage and issued-PC hold need no reset: gated by r_count / state
  always_ff @(posedge clk_i) begin
    if (w_gnt_take) r_issue_pc <= r_fetch_pc;
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata_i;
      r_buf_pc[r_wr_ptr]    <= r_issue_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory
// whose word at address A is (A << 7) | 0x13.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  opcode;

  int errors = 0;
  int checks = 0;
  int gnt_dly = 0;
  int rv_dly  = 0;
  logic [31:0] acc_pc[$], acc_instr[$], gnt_addr_q[$];

  instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .opcode_o(opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 7) | 32'h13;
  endfunction

  // Memory model: one outstanding access, grant after gnt_dly request cycles,
  // response rv_dly cycles after the cycle following the grant.
  initial begin : mem_model
    logic        m_pend;
    int          m_rv, m_g;
    logic [31:0] m_addr;
    m_pend = 1'b0; m_rv = 0; m_g = 0; m_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      if (m_pend) begin
        if (m_rv == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(m_addr); m_pend = 1'b0;
        end else m_rv--;
      end else if (imem_req) begin
        if (m_g >= gnt_dly) begin
          imem_gnt = 1'b1; m_addr = imem_addr; m_pend = 1'b1; m_rv = rv_dly; m_g = 0;
        end else m_g++;
      end else m_g = 0;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        if (instr_valid && instr_ready) begin
          acc_pc.push_back(instr_pc); acc_instr.push_back(instr);
        end
        if (imem_req && imem_gnt) gnt_addr_q.push_back(imem_addr);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (8) @(negedge clk);
    acc_pc.delete(); acc_instr.delete(); gnt_addr_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %h want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %h want 0", instr_valid); end
    checks++; if ({instr, instr_pc} !== 64'h0) begin errors++; $display("FAIL rst_data: got %h/%h want 0/0", instr, instr_pc); end
    checks++; if (opcode !== 7'h0) begin errors++; $display("FAIL rst_opcode: got %h want 0", opcode); end
  endtask

  task automatic test_first_fetch();
    gnt_dly = 0; rv_dly = 0; instr_ready = 1'b0;
    do_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL ff_req_c1: got req=%h addr=%h want 1/0", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ff_valid_c2: got %h want 0", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ff_valid_c3: got %h want 1", instr_valid); end
    checks++; if (instr !== 32'h13 || instr_pc !== 32'h0) begin errors++; $display("FAIL ff_head: got %h@%h want 13@0", instr, instr_pc); end
    checks++; if (opcode !== 7'b0010011) begin errors++; $display("FAIL ff_opcode: got %h want 13", opcode); end
  endtask

  task automatic test_backpressure();
    int n, g0;
    gnt_dly = 0; rv_dly = 0; instr_ready = 1'b0;
    do_reset();
    n = 0;
    while (gnt_addr_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    checks++; if (imem_req !== 1'b0 || gnt_addr_q.size() != 2) begin errors++; $display("FAIL bp_full_idle: got req=%h grants=%0d want 0/2", imem_req, gnt_addr_q.size()); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%h pc=%h want 1/0", instr_valid, instr_pc); end
    g0 = gnt_addr_q.size();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (acc_pc.size() != 1 || acc_pc[0] !== 32'h0) begin errors++; $display("FAIL bp_one_pop: got n=%0d want 1 pop of pc 0", acc_pc.size()); end
    checks++; if (gnt_addr_q.size() - g0 != 1 || gnt_addr_q[gnt_addr_q.size()-1] !== 32'h8) begin errors++; $display("FAIL bp_one_req: got %0d new grants want 1 to 8", gnt_addr_q.size() - g0); end
    checks++; if (instr_pc !== 32'h4 || instr !== 32'h213 || imem_req !== 1'b0) begin errors++; $display("FAIL bp_after: got %h@%h req=%h want 213@4 req=0", instr, instr_pc, imem_req); end
  endtask

  task automatic test_redirect_wait();
    int n;
    gnt_dly = 0; rv_dly = 2; instr_ready = 1'b0;
    do_reset();
    n = 0;
    while (!(imem_req && imem_gnt && imem_addr == 32'h4) && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL rw_grant4: got timeout want grant at 4"); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL rw_pre: got v=%h pc=%h want 1/0", instr_valid, instr_pc); end
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0; redirect_pc = '0;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL rw_flush: got v=%h addr=%h want 0/100", instr_valid, imem_addr); end
    instr_ready = 1'b1;
    n = 0;
    while (acc_pc.size() < 1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (acc_pc.size() < 1 || acc_pc[0] !== 32'h100 || acc_instr[0] !== 32'h8013) begin errors++; $display("FAIL rw_first: got n=%0d want 8013@100", acc_pc.size()); end
    checks++; if (gnt_addr_q.size() < 3 || gnt_addr_q[2] !== 32'h100) begin errors++; $display("FAIL rw_req_addr: got grants=%0d want third grant at 100", gnt_addr_q.size()); end
  endtask

  task automatic test_redirect_gnt();
    int n;
    gnt_dly = 0; rv_dly = 0; instr_ready = 1'b1;
    do_reset();
    n = 0;
    while (!(imem_req && imem_gnt) && n < 50) begin @(negedge clk); n++; end
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0; redirect_pc = '0;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin errors++; $display("FAIL rg_c1: got v=%h addr=%h want 0/200", instr_valid, imem_addr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL rg_dropped: got v=%h req=%h want 0/1", instr_valid, imem_req); end
    n = 0;
    while (acc_pc.size() < 1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (acc_pc.size() < 1 || acc_pc[0] !== 32'h200 || acc_instr[0] !== 32'h10013) begin errors++; $display("FAIL rg_first: got n=%0d want 10013@200", acc_pc.size()); end
    checks++; if (gnt_addr_q.size() < 2 || gnt_addr_q[1] !== 32'h200) begin errors++; $display("FAIL rg_req_addr: got grants=%0d want second grant at 200", gnt_addr_q.size()); end
  endtask

  task automatic test_slow_mem();
    int n, w;
    logic [31:0] a;
    logic stable;
    gnt_dly = 3; rv_dly = 2; instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!imem_req && n < 50) begin @(negedge clk); n++; end
      a = imem_addr; w = 0; stable = 1'b1;
      while (!imem_gnt && w < 20) begin
        @(negedge clk); w++;
        if (imem_addr !== a) stable = 1'b0;
      end
      checks++; if (a !== 32'(k * 4) || !stable || w != 3) begin errors++; $display("FAIL sm_req%0d: got addr=%h stable=%0d wait=%0d want %h/1/3", k, a, stable, w, k * 4); end
      @(negedge clk);
    end
    n = 0;
    while (acc_pc.size() < 3 && n < 80) begin @(negedge clk); n++; end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (acc_pc.size() <= k || acc_pc[k] !== 32'(k * 4) || acc_instr[k] !== mem_word(32'(k * 4))) begin
        errors++; $display("FAIL sm_order%0d: got n=%0d want %h@%h", k, acc_pc.size(), mem_word(32'(k * 4)), k * 4);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    gnt_dly = 0; rv_dly = 5; instr_ready = 1'b0;
    do_reset();
    n = 0;
    while (!(imem_req && imem_gnt && imem_addr == 32'h4) && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rm_pre: got v=%h want 1", instr_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rm_async: got req=%h addr=%h v=%h want 0/0/0", imem_req, imem_addr, instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || opcode !== 7'h0) begin errors++; $display("FAIL rm_outs: got %h@%h op=%h want 0", instr, instr_pc, opcode); end
    repeat (2) @(negedge clk);
    acc_pc.delete(); acc_instr.delete(); gnt_addr_q.delete();
    rst_n = 1'b1; instr_ready = 1'b1;
    n = 0;
    while (acc_pc.size() < 1 && n < 60) begin @(negedge clk); n++; end
    checks++; if (acc_pc.size() < 1 || acc_pc[0] !== 32'h0 || acc_instr[0] !== 32'h13) begin errors++; $display("FAIL rm_restart: got n=%0d want 13@0", acc_pc.size()); end
    checks++; if (gnt_addr_q.size() < 1 || gnt_addr_q[0] !== 32'h0) begin errors++; $display("FAIL rm_first_req: got grants=%0d want first at 0", gnt_addr_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_slow_mem();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
